wasca_abus_ram_adapter: RTL

Bridges the 16-bit A-bus access path onto the 32-bit single-port on-chip RAM (15000 words, 14-bit word address, byte enables, one-cycle registered-address read). Sits directly upstream of the RAM. Converts halfword requests into RAM word accesses with the correct byte lanes. Enforces the RAM's read latency, bounds-checks addresses, and returns a single-cycle acknowledge to the host side.

---
 rtl/wasca_abus_ram_adapter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wasca_abus_ram_adapter.sv
// Bridges 16-bit A-bus halfword requests onto the 32-bit byte-enabled single-port RAM.
// Latency: write ack 2 cycles, read ack 3 cycles; no backpressure, requests while busy are dropped and flagged.
module wasca_abus_ram_adapter #(
    parameter int NUM_WORDS = 15000,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W:0]   host_addr,
    input  logic [1:0]        host_be,
    input  logic [15:0]       host_wdata,
    output logic [15:0]       host_rdata,
    output logic              host_ack,
    output logic              host_busy,
    output logic              host_overrun,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    output logic              ram_reset_req,
    input  logic [31:0]       ram_readdata
);

    localparam logic [ADDR_W:0] LP_NUM_WORDS = NUM_WORDS[ADDR_W:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_wr;
    logic [ADDR_W:0] r_addr;
    logic [1:0]      r_be;
    logic [15:0]     r_wdata;
    logic            r_in_range;
    logic [15:0]     r_rdata;
    logic            r_overrun;
    logic [15:0]     r_err_count;
    logic            w_req_in_range;

    assign w_req_in_range = ({1'b0, host_addr[ADDR_W:1]} < LP_NUM_WORDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (host_req) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = r_wr ? S_DONE : S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are gated by the range check so an out-of-range access never touches the RAM.
    always_comb begin
        host_ack       = 1'b0;
        host_busy      = 1'b1;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        case (r_state)
            S_IDLE:  host_busy = 1'b0;
            S_ISSUE: begin
                ram_chipselect = r_in_range;
                ram_write      = r_wr & r_in_range;
            end
            S_DONE:  host_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_be        <= 2'b00;
            r_wdata     <= 16'h0000;
            r_in_range  <= 1'b0;
            r_rdata     <= 16'h0000;
            r_overrun   <= 1'b0;
            r_err_count <= 16'h0000;
        end else begin
            if (r_state == S_IDLE && host_req) begin
                r_wr       <= host_wr;
                r_addr     <= host_addr;
                r_be       <= host_be;
                r_wdata    <= host_wdata;
                r_in_range <= w_req_in_range;
            end
            if (r_state != S_IDLE && host_req) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_ISSUE && !r_in_range && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (r_state == S_CAPTURE) begin
                if (r_in_range) begin
                    r_rdata <= r_addr[0] ? ram_readdata[31:16] : ram_readdata[15:0];
                end else begin
                    r_rdata <= 16'hFFFF;
                end
            end
        end
    end

    assign host_rdata     = r_rdata;
    assign host_overrun   = r_overrun;
    assign err_count      = r_err_count;
    assign ram_address    = r_addr[ADDR_W:1];
    assign ram_byteenable = r_addr[0] ? {r_be, 2'b00} : {2'b00, r_be};
    assign ram_writedata  = {r_wdata, r_wdata};
    assign ram_clken      = ~reset;
    assign ram_reset_req  = 1'b0;

endmodule
